// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    int v;
    v = $clog2(w);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder used as the per-bit datapath of serial_adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic hs1, hc1, hc2;

  // Two half-adder stages: a+b, then the partial sum + cin.
  assign hs1  = a ^ b;
  assign hc1  = a & b;
  assign s    = hs1 ^ cin;
  assign hc2  = hs1 & cin;
  assign cout = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, LSB first, one bit per clock, valid/ready on both sides.
//   state | meaning
//   IDLE  | waiting for operands, in_ready=1
//   RUN   | processing bit cnt each cycle
//   DONE  | result held, out_valid=1 until out_ready
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_nxt;
  logic             a_bit, b_bit, fa_s, fa_cout;
  logic             accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  // Compare-based bit select keeps the index width independent of WIDTH.
  always_comb begin
    a_bit = 1'b0;
    b_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt == CW'(i)) begin
        a_bit = a_q[i];
        b_bit = b_q[i];
      end
    end
  end

  always_comb begin
    res_nxt = res_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt == CW'(i)) res_nxt[i] = fa_s;
    end
  end

  full_adder_cell u_fa (
    .a    (a_bit),
    .b    (b_bit),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub;
      cnt     <= '0;
    end else if (state == RUN) begin
      cnt     <= cnt + CW'(1);
      carry_q <= fa_cout;
      res_q   <= res_nxt;
      // Outputs only move at the MSB step so they stay stable outside DONE.
      if (cnt == LAST) begin
        sum       <= res_nxt;
        carry_out <= fa_cout;
        overflow  <= carry_q ^ fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid, in_ready, sub, out_valid, out_ready, carry_out, overflow;
  logic [7:0] a, b, sum;

  logic       in_valid_w1, in_ready_w1, sub_w1, out_valid_w1, out_ready_w1;
  logic       carry_out_w1, overflow_w1;
  logic [0:0] a_w1, b_w1, sum_w1;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w1), .in_ready(in_ready_w1),
    .a(a_w1), .b(b_w1), .sub(sub_w1), .out_valid(out_valid_w1), .out_ready(out_ready_w1),
    .sum(sum_w1), .carry_out(carry_out_w1), .overflow(overflow_w1)
  );

  typedef struct {
    logic [63:0] sum;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                 input logic s);
    logic [64:0] full;
    logic [63:0] mask, xx, yy;
    exp_t        e;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    xx   = x & mask;
    yy   = (s ? ~y : y) & mask;
    full = {1'b0, xx} + {1'b0, yy} + 65'(s);
    e.sum = full[63:0] & mask;
    e.co  = full[w];
    if (s) e.ov = (xx[w-1] != y[w-1]) && (e.sum[w-1] != xx[w-1]);
    else   e.ov = (xx[w-1] == y[w-1]) && (e.sum[w-1] != xx[w-1]);
    return e;
  endfunction

  task automatic do_op8(input logic [7:0] xa, input logic [7:0] xb, input logic xs,
                        input string name);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    a = xa; b = xb; sub = xs; in_valid = 1'b1;
    sb_q.push_back(model(8, 64'(xa), 64'(xb), xs));
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL %s latency got=%0d exp=8", name, n);
    end
    e = sb_q.pop_front();
    checks++;
    if ({out_valid, sum, carry_out, overflow} !== {1'b1, e.sum[7:0], e.co, e.ov}) begin
      failures++;
      $display("FAIL %s result got v=%b sum=%h co=%b ov=%b exp v=1 sum=%h co=%b ov=%b",
               name, out_valid, sum, carry_out, overflow, e.sum[7:0], e.co, e.ov);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s return_idle got v=%b rdy=%b exp v=0 rdy=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, sum, carry_out, overflow} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset8 got rdy=%b v=%b sum=%h co=%b ov=%b exp rdy=1 v=0 sum=00 co=0 ov=0",
               in_ready, out_valid, sum, carry_out, overflow);
    end
    checks++;
    if ({in_ready_w1, out_valid_w1, sum_w1, carry_out_w1, overflow_w1} !== 5'b10000) begin
      failures++;
      $display("FAIL reset1 got %b exp 10000",
               {in_ready_w1, out_valid_w1, sum_w1, carry_out_w1, overflow_w1});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_vectors;
    do_op8(8'h0F, 8'h01, 1'b0, "add_0f_01");
    do_op8(8'hFF, 8'h01, 1'b0, "add_ff_01");
    do_op8(8'h7F, 8'h01, 1'b0, "add_7f_01");
    do_op8(8'h05, 8'h07, 1'b1, "sub_05_07");
    do_op8(8'h80, 8'h01, 1'b1, "sub_80_01");
    do_op8(8'h00, 8'h00, 1'b1, "sub_00_00");
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++)
      do_op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), "random");
  endtask

  task automatic test_backpressure;
    exp_t e;
    int   n;
    a = 8'h12; b = 8'h34; sub = 1'b0; in_valid = 1'b1;
    sb_q.push_back(model(8, 64'h12, 64'h34, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    e = sb_q.pop_front();
    in_valid = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, sum, carry_out, overflow} !== {1'b1, 1'b0, e.sum[7:0], e.co, e.ov}) begin
        failures++;
        $display("FAIL backpressure_hold cyc=%0d got v=%b rdy=%b sum=%h co=%b ov=%b exp v=1 rdy=0 sum=%h co=%b ov=%b",
                 k, out_valid, in_ready, sum, carry_out, overflow, e.sum[7:0], e.co, e.ov);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== e.sum[7:0]) begin
      failures++;
      $display("FAIL backpressure_release got v=%b rdy=%b sum=%h exp v=0 rdy=1 sum=%h",
               out_valid, in_ready, sum, e.sum[7:0]);
    end
  endtask

  task automatic test_reset_mid_run;
    a = 8'h33; b = 8'h44; sub = 1'b0; in_valid = 1'b1;
    sb_q.push_back(model(8, 64'h33, 64'h44, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    sb_q.delete();
    checks++;
    if ({out_valid, sum, carry_out, overflow, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid_run got v=%b sum=%h co=%b ov=%b rdy=%b exp v=0 sum=00 co=0 ov=0 rdy=1",
               out_valid, sum, carry_out, overflow, in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_run_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
    end
    do_op8(8'h01, 8'h02, 1'b0, "post_reset");
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   sent, got;
    logic both;
    sent = 0; got = 0; both = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
      if (in_ready && out_valid) both = 1'b1;
      if (out_valid && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        got++;
        checks++;
        if ({sum, carry_out, overflow} !== {e.sum[7:0], e.co, e.ov}) begin
          failures++;
          $display("FAIL back_to_back op=%0d got sum=%h co=%b ov=%b exp sum=%h co=%b ov=%b",
                   got, sum, carry_out, overflow, e.sum[7:0], e.co, e.ov);
        end
      end
      if (in_ready && sent < 4) begin
        a = 8'($urandom); b = 8'($urandom); sub = sent[0];
        sb_q.push_back(model(8, 64'(a), 64'(b), sub));
        in_valid = 1'b1;
        sent++;
      end else if (in_ready) begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got !== 4 || both !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_count got results=%0d overlap=%b exp results=4 overlap=0", got, both);
    end
  endtask

  task automatic test_width1;
    exp_t e;
    int   n;
    for (int i = 0; i < 8; i++) begin
      a_w1 = 1'(i); b_w1 = 1'(i >> 1); sub_w1 = 1'(i >> 2); in_valid_w1 = 1'b1;
      sb_q.push_back(model(1, 64'(i & 1), 64'((i >> 1) & 1), 1'(i >> 2)));
      @(posedge clk); #1;
      in_valid_w1 = 1'b0;
      n = 0;
      while (!out_valid_w1 && n < 20) begin @(posedge clk); #1; n++; end
      e = sb_q.pop_front();
      checks++;
      if (n !== 1 || {sum_w1, carry_out_w1, overflow_w1} !== {e.sum[0], e.co, e.ov}) begin
        failures++;
        $display("FAIL width1 a=%0d b=%0d sub=%0d got lat=%0d sum=%b co=%b ov=%b exp lat=1 sum=%b co=%b ov=%b",
                 i & 1, (i >> 1) & 1, (i >> 2) & 1, n, sum_w1, carry_out_w1, overflow_w1,
                 e.sum[0], e.co, e.ov);
      end
      out_ready_w1 = 1'b1;
      @(posedge clk); #1;
      out_ready_w1 = 1'b0;
    end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    in_valid_w1 = 1'b0; out_ready_w1 = 1'b0; a_w1 = '0; b_w1 = '0; sub_w1 = 1'b0;
    test_reset();
    test_vectors();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_width1();
    checks++;
    if (sb_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
